sys_pe_ws: RTL and testbench

Parametrised weight-stationary systolic processing element, the successor to the fixed 8/8/32-bit SysPE. It holds one stationary weight and forwards the weight stream to PEs further down the column. Each transfer it multiplies an activation by the held weight, adds the partial sum from upstream, and passes the activation and the new partial sum on. Every channel uses the busy/vld/data point-to-point handshake, so PEs tile directly into an N×M array.

---
 rtl/sys_pe_pkg.sv | 32 +++
 rtl/p2p_out_slot.sv | 29 ++
 rtl/sys_pe_ws.sv | 123 ++++++++++++
 tb/tb_sys_pe_ws.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pe_pkg.sv
// Shared widths and arithmetic helpers for the weight-stationary systolic PE.
package sys_pe_pkg;

   localparam int ACT_W_DEF = 8;
   localparam int WGT_W_DEF = 8;
   localparam int ACC_W_DEF = 32;
   localparam int SUM_W     = 64;

   // Accumulator must hold the full product and fit inside the add width.
   function automatic bit widths_ok(input int act_w, input int wgt_w,
                                    input int acc_w);
      return (acc_w >= act_w + wgt_w) && (acc_w < SUM_W);
   endfunction

   function automatic logic signed [SUM_W-1:0] sat_add(
      input logic signed [SUM_W-1:0] a,
      input logic signed [SUM_W-1:0] b,
      input int                      acc_w,
      input bit                      sat
   );
      logic signed [SUM_W-1:0] s;
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      s  = a + b;
      hi = (SUM_W'(1) << (acc_w - 1)) - SUM_W'(1);
      lo = -hi - SUM_W'(1);
      if (sat && (s > hi)) return hi;
      if (sat && (s < lo)) return lo;
      return s;
   endfunction

endpackage

// File: rtl/p2p_out_slot.sv
// One-entry busy/vld output register; free when empty or draining.
module p2p_out_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         busy,
   output logic         vld,
   output logic [W-1:0] data,
   output logic         free
);

   assign free = !vld || !busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (load) begin
         vld  <= 1'b1;
         data <= load_data;
      end else if (free) begin
         vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/sys_pe_ws.sv
// Weight-stationary systolic PE: forwards weights, MACs act x weight
// into the upstream partial sum, forwards act and sum downstream.
module sys_pe_ws
   import sys_pe_pkg::*;
#(
   parameter int ACT_W   = ACT_W_DEF,
   parameter int WGT_W   = WGT_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int FWD_CNT = 0,
   parameter int SAT     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             weight_in_vld,
   input  logic [WGT_W-1:0] weight_in_data,
   output logic             weight_in_busy,
   input  logic             act_in_vld,
   input  logic [ACT_W-1:0] act_in_data,
   output logic             act_in_busy,
   input  logic             accum_in_vld,
   input  logic [ACC_W-1:0] accum_in_data,
   output logic             accum_in_busy,
   output logic             weight_out_vld,
   output logic [WGT_W-1:0] weight_out_data,
   input  logic             weight_out_busy,
   output logic             act_out_vld,
   output logic [ACT_W-1:0] act_out_data,
   input  logic             act_out_busy,
   output logic             accum_out_vld,
   output logic [ACC_W-1:0] accum_out_data,
   input  logic             accum_out_busy
);

   if (!widths_ok(ACT_W, WGT_W, ACC_W)) begin : g_width_check
      $error("sys_pe_ws: ACC_W must be >= ACT_W+WGT_W and < 64");
   end

   localparam logic [7:0] FWD_LAST = 8'(FWD_CNT);

   logic                            w_free;
   logic                            a_free;
   logic                            s_free;
   logic [7:0]                      wcnt;
   logic                            wgt_loaded;
   logic signed [WGT_W-1:0]         wgt_reg;
   logic                            at_last;
   logic                            w_xfer;
   logic                            w_fwd;
   logic                            w_latch;
   logic                            fire_ok;
   logic                            fire;
   logic signed [ACT_W-1:0]         act_s;
   logic signed [ACC_W-1:0]         acc_s;
   logic signed [ACT_W+WGT_W-1:0]   prod;
   logic [ACC_W-1:0]                accum_next;

   assign at_last        = (wcnt == FWD_LAST);
   assign weight_in_busy = rst || !(at_last || w_free);
   assign w_xfer         = weight_in_vld && !weight_in_busy;
   assign w_fwd          = w_xfer && !at_last;
   assign w_latch        = w_xfer && at_last;

   // Both inputs see the same gate so they always transfer together.
   assign fire_ok       = !rst && wgt_loaded && a_free && s_free;
   assign act_in_busy   = !(accum_in_vld && fire_ok);
   assign accum_in_busy = !(act_in_vld && fire_ok);
   assign fire          = act_in_vld && accum_in_vld && fire_ok;

   assign act_s      = act_in_data;
   assign acc_s      = accum_in_data;
   assign prod       = act_s * wgt_reg;
   assign accum_next = ACC_W'(sat_add(SUM_W'(acc_s), SUM_W'(prod),
                                      ACC_W, SAT != 0));

   // A latch in the same cycle as a fire only affects later fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt       <= '0;
         wgt_loaded <= 1'b0;
         wgt_reg    <= '0;
      end else if (w_latch) begin
         wcnt       <= '0;
         wgt_loaded <= 1'b1;
         wgt_reg    <= weight_in_data;
      end else if (w_fwd) begin
         wcnt       <= wcnt + 8'd1;
      end
   end

   p2p_out_slot #(.W(WGT_W)) u_wgt_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_fwd),
      .load_data (weight_in_data),
      .busy      (weight_out_busy),
      .vld       (weight_out_vld),
      .data      (weight_out_data),
      .free      (w_free)
   );

   p2p_out_slot #(.W(ACT_W)) u_act_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (fire),
      .load_data (act_in_data),
      .busy      (act_out_busy),
      .vld       (act_out_vld),
      .data      (act_out_data),
      .free      (a_free)
   );

   p2p_out_slot #(.W(ACC_W)) u_acc_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (fire),
      .load_data (accum_next),
      .busy      (accum_out_busy),
      .vld       (accum_out_vld),
      .data      (accum_out_data),
      .free      (s_free)
   );

endmodule

// File: tb/tb_sys_pe_ws.sv
// Directed self-checking bench for sys_pe_ws (wrap and saturating builds).
module tb_sys_pe_ws;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic        w_in_vld, w_in_busy, a_in_vld, a_in_busy, c_in_vld, c_in_busy;
   logic [7:0]  w_in_data, a_in_data;
   logic [31:0] c_in_data;
   logic        w_out_vld, w_out_busy, a_out_vld, a_out_busy;
   logic        c_out_vld, c_out_busy;
   logic [7:0]  w_out_data, a_out_data;
   logic [31:0] c_out_data;

   logic        s_w_in_vld, s_w_in_busy, s_a_in_vld, s_a_in_busy;
   logic        s_c_in_vld, s_c_in_busy;
   logic [7:0]  s_w_in_data, s_a_in_data;
   logic [31:0] s_c_in_data;
   logic        s_w_out_vld, s_a_out_vld, s_c_out_vld;
   logic [7:0]  s_w_out_data, s_a_out_data;
   logic [31:0] s_c_out_data;

   sys_pe_ws #(.ACT_W(8), .WGT_W(8), .ACC_W(32), .FWD_CNT(2), .SAT(0)) u_main (
      .clk(clk), .rst(rst),
      .weight_in_vld(w_in_vld), .weight_in_data(w_in_data),
      .weight_in_busy(w_in_busy),
      .act_in_vld(a_in_vld), .act_in_data(a_in_data), .act_in_busy(a_in_busy),
      .accum_in_vld(c_in_vld), .accum_in_data(c_in_data),
      .accum_in_busy(c_in_busy),
      .weight_out_vld(w_out_vld), .weight_out_data(w_out_data),
      .weight_out_busy(w_out_busy),
      .act_out_vld(a_out_vld), .act_out_data(a_out_data),
      .act_out_busy(a_out_busy),
      .accum_out_vld(c_out_vld), .accum_out_data(c_out_data),
      .accum_out_busy(c_out_busy)
   );

   sys_pe_ws #(.ACT_W(8), .WGT_W(8), .ACC_W(32), .FWD_CNT(0), .SAT(1)) u_sat (
      .clk(clk), .rst(rst),
      .weight_in_vld(s_w_in_vld), .weight_in_data(s_w_in_data),
      .weight_in_busy(s_w_in_busy),
      .act_in_vld(s_a_in_vld), .act_in_data(s_a_in_data),
      .act_in_busy(s_a_in_busy),
      .accum_in_vld(s_c_in_vld), .accum_in_data(s_c_in_data),
      .accum_in_busy(s_c_in_busy),
      .weight_out_vld(s_w_out_vld), .weight_out_data(s_w_out_data),
      .weight_out_busy(1'b0),
      .act_out_vld(s_a_out_vld), .act_out_data(s_a_out_data),
      .act_out_busy(1'b0),
      .accum_out_vld(s_c_out_vld), .accum_out_data(s_c_out_data),
      .accum_out_busy(1'b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic load_weight(input logic [7:0] w);
      for (int i = 0; i < 3; i++) begin
         w_in_vld  = 1'b1;
         w_in_data = (i == 2) ? w : 8'(8'h11 + i);
         step();
      end
      w_in_vld = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step();
      step();
      total++;
      if ({w_out_vld, a_out_vld, c_out_vld} !== 3'b000) begin
         bad++;
         $display("FAIL reset_vld got=%b want=000",
                  {w_out_vld, a_out_vld, c_out_vld});
      end
      total++;
      if ({w_in_busy, a_in_busy, c_in_busy} !== 3'b111) begin
         bad++;
         $display("FAIL reset_busy got=%b want=111",
                  {w_in_busy, a_in_busy, c_in_busy});
      end
      rst = 1'b0;
      a_in_vld = 1'b1;
      c_in_vld = 1'b1;
      #1;
      total++;
      if ({w_in_busy, a_in_busy, c_in_busy} !== 3'b011) begin
         bad++;
         $display("FAIL post_reset_busy got=%b want=011",
                  {w_in_busy, a_in_busy, c_in_busy});
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
      step();
   endtask

   task automatic test_weight_fwd;
      logic [7:0] ws [3];
      ws[0] = 8'd5; ws[1] = 8'd6; ws[2] = 8'd7;
      for (int i = 0; i < 3; i++) begin
         w_in_vld  = 1'b1;
         w_in_data = ws[i];
         #1;
         total++;
         if (w_in_busy !== 1'b0) begin
            bad++;
            $display("FAIL wfwd_busy%0d got=%b want=0", i, w_in_busy);
         end
         step();
         if (i < 2) begin
            total++;
            if (w_out_vld !== 1'b1 || w_out_data !== ws[i]) begin
               bad++;
               $display("FAIL wfwd_out%0d got=%b/%0d want=1/%0d",
                        i, w_out_vld, w_out_data, ws[i]);
            end
         end else begin
            total++;
            if (w_out_vld !== 1'b0) begin
               bad++;
               $display("FAIL wfwd_no7 got vld=%b data=%0d want vld=0",
                        w_out_vld, w_out_data);
            end
         end
      end
      w_in_vld  = 1'b0;
      a_in_vld  = 1'b1;
      a_in_data = 8'd1;
      c_in_vld  = 1'b1;
      c_in_data = 32'd0;
      step();
      total++;
      if (c_out_vld !== 1'b1 || c_out_data !== 32'd7) begin
         bad++;
         $display("FAIL wfwd_wgt7 got=%b/%0d want=1/7", c_out_vld, c_out_data);
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
      step();
   endtask

   task automatic test_stream;
      load_weight(8'hFD);
      a_in_vld  = 1'b1;
      a_in_data = 8'd4;
      c_in_vld  = 1'b1;
      c_in_data = 32'd100;
      step();
      total++;
      if (c_out_vld !== 1'b1 || c_out_data !== 32'd88) begin
         bad++;
         $display("FAIL stream_acc got=%b/%0d want=1/88", c_out_vld, c_out_data);
      end
      total++;
      if (a_out_vld !== 1'b1 || a_out_data !== 8'd4) begin
         bad++;
         $display("FAIL stream_act got=%b/%0d want=1/4", a_out_vld, a_out_data);
      end
      for (int i = 1; i <= 8; i++) begin
         a_in_data = 8'(i);
         c_in_data = 32'(i * 10);
         #1;
         total++;
         if (a_in_busy !== 1'b0 || c_in_busy !== 1'b0) begin
            bad++;
            $display("FAIL burst_busy%0d got=%b%b want=00", i, a_in_busy, c_in_busy);
         end
         step();
         total++;
         if (c_out_vld !== 1'b1 || c_out_data !== 32'(i * 7)) begin
            bad++;
            $display("FAIL burst_acc%0d got=%b/%0d want=1/%0d",
                     i, c_out_vld, c_out_data, i * 7);
         end
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
      step();
   endtask

   task automatic test_backpressure;
      c_out_busy = 1'b1;
      a_in_vld   = 1'b1;
      a_in_data  = 8'd2;
      c_in_vld   = 1'b1;
      c_in_data  = 32'd50;
      step();
      a_in_data = 8'd3;
      c_in_data = 32'd60;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (c_out_vld !== 1'b1 || c_out_data !== 32'd44) begin
            bad++;
            $display("FAIL bp_hold%0d got=%b/%0d want=1/44", i, c_out_vld, c_out_data);
         end
         total++;
         if (a_in_busy !== 1'b1 || c_in_busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_busy%0d got=%b%b want=11", i, a_in_busy, c_in_busy);
         end
         step();
      end
      c_out_busy = 1'b0;
      #1;
      total++;
      if (a_in_busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_release_busy got=%b want=0", a_in_busy);
      end
      step();
      total++;
      if (c_out_data !== 32'd51 || a_out_data !== 8'd3) begin
         bad++;
         $display("FAIL bp_next got=%0d/%0d want=51/3", c_out_data, a_out_data);
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
      step();
      total++;
      if (c_out_vld !== 1'b0) begin
         bad++;
         $display("FAIL bp_nodup got=%b want=0", c_out_vld);
      end
   endtask

   task automatic test_weight_update;
      w_in_vld  = 1'b1;
      w_in_data = 8'd1;
      step();
      w_in_data = 8'd2;
      step();
      w_in_data = 8'd4;
      a_in_vld  = 1'b1;
      a_in_data = 8'd5;
      c_in_vld  = 1'b1;
      c_in_data = 32'd0;
      step();
      w_in_vld = 1'b0;
      total++;
      if (c_out_data !== 32'hFFFF_FFF1) begin
         bad++;
         $display("FAIL wupd_old got=%0h want=fffffff1", c_out_data);
      end
      step();
      total++;
      if (c_out_data !== 32'd20) begin
         bad++;
         $display("FAIL wupd_new got=%0d want=20", c_out_data);
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
      step();
   endtask

   task automatic test_wrap;
      load_weight(8'h7F);
      a_in_vld  = 1'b1;
      a_in_data = 8'h7F;
      c_in_vld  = 1'b1;
      c_in_data = 32'h7FFF_FFF0;
      step();
      total++;
      if (c_out_data !== 32'h8000_3EF1) begin
         bad++;
         $display("FAIL wrap got=%0h want=80003ef1", c_out_data);
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
      step();
   endtask

   task automatic test_saturate;
      s_w_in_vld  = 1'b1;
      s_w_in_data = 8'h7F;
      step();
      s_w_in_vld  = 1'b0;
      s_a_in_vld  = 1'b1;
      s_a_in_data = 8'h7F;
      s_c_in_vld  = 1'b1;
      s_c_in_data = 32'h7FFF_FFF0;
      step();
      total++;
      if (s_c_out_vld !== 1'b1 || s_c_out_data !== 32'h7FFF_FFFF) begin
         bad++;
         $display("FAIL sat_pos got=%b/%0h want=1/7fffffff", s_c_out_vld, s_c_out_data);
      end
      s_a_in_vld  = 1'b0;
      s_c_in_vld  = 1'b0;
      s_w_in_vld  = 1'b1;
      s_w_in_data = 8'h80;
      step();
      s_w_in_vld  = 1'b0;
      s_a_in_vld  = 1'b1;
      s_c_in_vld  = 1'b1;
      s_a_in_data = 8'h7F;
      s_c_in_data = 32'h8000_0000;
      step();
      total++;
      if (s_c_out_data !== 32'h8000_0000) begin
         bad++;
         $display("FAIL sat_neg got=%0h want=80000000", s_c_out_data);
      end
      s_a_in_data = 8'hFF;
      step();
      total++;
      if (s_c_out_data !== 32'h8000_0080) begin
         bad++;
         $display("FAIL sat_inrange got=%0h want=80000080", s_c_out_data);
      end
      s_a_in_vld = 1'b0;
      s_c_in_vld = 1'b0;
      step();
   endtask

   task automatic test_reset_mid;
      w_out_busy = 1'b1;
      a_out_busy = 1'b1;
      c_out_busy = 1'b1;
      w_in_vld   = 1'b1;
      w_in_data  = 8'd9;
      a_in_vld   = 1'b1;
      a_in_data  = 8'd1;
      c_in_vld   = 1'b1;
      c_in_data  = 32'd1;
      step();
      w_in_vld = 1'b0;
      total++;
      if ({w_out_vld, a_out_vld, c_out_vld} !== 3'b111) begin
         bad++;
         $display("FAIL rmid_full got=%b want=111", {w_out_vld, a_out_vld, c_out_vld});
      end
      rst = 1'b1;
      step();
      total++;
      if ({w_out_vld, a_out_vld, c_out_vld} !== 3'b000) begin
         bad++;
         $display("FAIL rmid_vld got=%b want=000", {w_out_vld, a_out_vld, c_out_vld});
      end
      total++;
      if ({w_in_busy, a_in_busy, c_in_busy} !== 3'b111) begin
         bad++;
         $display("FAIL rmid_busy got=%b want=111", {w_in_busy, a_in_busy, c_in_busy});
      end
      rst        = 1'b0;
      w_out_busy = 1'b0;
      a_out_busy = 1'b0;
      c_out_busy = 1'b0;
      #1;
      total++;
      if ({w_in_busy, a_in_busy, c_in_busy} !== 3'b011) begin
         bad++;
         $display("FAIL rmid_release got=%b want=011", {w_in_busy, a_in_busy, c_in_busy});
      end
      step();
      total++;
      if (a_in_busy !== 1'b1 || c_out_vld !== 1'b0) begin
         bad++;
         $display("FAIL rmid_nofire got=%b/%b want=1/0", a_in_busy, c_out_vld);
      end
      a_in_vld = 1'b0;
      c_in_vld = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      w_in_vld = 1'b0; w_in_data = '0;
      a_in_vld = 1'b0; a_in_data = '0;
      c_in_vld = 1'b0; c_in_data = '0;
      w_out_busy = 1'b0; a_out_busy = 1'b0; c_out_busy = 1'b0;
      s_w_in_vld = 1'b0; s_w_in_data = '0;
      s_a_in_vld = 1'b0; s_a_in_data = '0;
      s_c_in_vld = 1'b0; s_c_in_data = '0;
      test_reset();
      test_weight_fwd();
      test_stream();
      test_backpressure();
      test_weight_update();
      test_wrap();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
